// File: rtl/decodificador_teclado_if.sv
// rtl/decodificador_teclado_if.sv - keypad decoder signal bundle
// Purpose: groups the scanner row drive, keypad columns and decoded key outputs.
// Ports:
//   ent_teclado  row drive from the scanner (1111 = frame marker, one-hot = row)
//   sal_teclado  keypad column lines (bit 3 = column 0)
//   tecla        last accepted key code
//   valida       one-cycle strobe for an accepted key
//   presionada   key considered held
// Modports: slave = decoder side, master = scanner/keypad/consumer side.
interface decodificador_teclado_if;
    logic [3:0] ent_teclado;
    logic [3:0] sal_teclado;
    logic [3:0] tecla;
    logic       valida;
    logic       presionada;

    modport slave (
        input  ent_teclado,
        input  sal_teclado,
        output tecla,
        output valida,
        output presionada
    );

    modport master (
        output ent_teclado,
        output sal_teclado,
        input  tecla,
        input  valida,
        input  presionada
    );
endinterface

// File: rtl/decodificador_teclado.sv
// rtl/decodificador_teclado.sv - 4x4 keypad decoder with frame debounce
// Purpose: scores each scan frame (none / single key / multiple keys), debounces
//   the result over DEB_FRAMES whole frames and emits a key code with a strobe.
// Ports:
//   clk    system clock (same clock as the row scanner)
//   rst_n  asynchronous active-low reset
//   bus    decodificador_teclado_if.slave (ent_teclado, sal_teclado in;
//          tecla, valida, presionada out)
// Parameters: DEB_FRAMES (1..15), REP_FRAMES (1..63, auto-repeat only).
// Optional feature: define TECLADO_REPEAT_EN to re-strobe a held key every
//   REP_FRAMES frames.
module decodificador_teclado #(
    parameter int DEB_FRAMES = 3,
    parameter int REP_FRAMES = 20
) (
    input  logic                    clk,
    input  logic                    rst_n,
    decodificador_teclado_if.slave  bus
);
    if (DEB_FRAMES < 1 || DEB_FRAMES > 15) begin : g_bad_deb
        $error("DEB_FRAMES out of range 1..15");
    end
    if (REP_FRAMES < 1 || REP_FRAMES > 63) begin : g_bad_rep
        $error("REP_FRAMES out of range 1..63");
    end

    localparam logic [3:0] DEB_L = 4'(DEB_FRAMES);

    typedef enum logic [1:0] {ST_IDLE, ST_CONFIRM, ST_HELD, ST_RELEASE} estado_t;

    // Columns are synchronized through 2 FFs; the row drive is delayed by the
    // same amount so that fila_d and col_s2 describe the same scan cycle.
    logic [3:0] col_s1, col_s2, fila_d1, fila_d, fila_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_s1    <= '0;
            col_s2    <= '0;
            fila_d1   <= '0;
            fila_d    <= '0;
            fila_prev <= '0;
        end else begin
            col_s1    <= bus.sal_teclado;
            col_s2    <= col_s1;
            fila_d1   <= bus.ent_teclado;
            fila_d    <= fila_d1;
            fila_prev <= fila_d;
        end
    end

    logic       frame_end, fila_onehot, col_onehot, hit;
    logic [1:0] row_idx, col_idx;
    logic [3:0] hit_code;

    assign frame_end = (fila_d == 4'b1111) && (fila_prev != 4'b1111);

    always_comb begin
        fila_onehot = 1'b1;
        row_idx     = 2'd0;
        case (fila_d)
            4'b1000: row_idx = 2'd0;
            4'b0100: row_idx = 2'd1;
            4'b0010: row_idx = 2'd2;
            4'b0001: row_idx = 2'd3;
            default: fila_onehot = 1'b0;
        endcase
    end

    // Column bit 3 is column 0. A row with several columns is still a hit but
    // marks the frame as multi.
    always_comb begin
        col_onehot = 1'b1;
        col_idx    = 2'd0;
        case (col_s2)
            4'b1000: col_idx = 2'd0;
            4'b0100: col_idx = 2'd1;
            4'b0010: col_idx = 2'd2;
            4'b0001: col_idx = 2'd3;
            default: col_onehot = 1'b0;
        endcase
    end

    assign hit      = fila_onehot && (col_s2 != 4'b0000);
    assign hit_code = {row_idx, col_idx};

    // Frame accumulators. armed stays low until the first frame end so that
    // the partial frame seen right after reset never feeds the FSM.
    logic       armed, acc_hit, acc_multi;
    logic [3:0] acc_code;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed     <= 1'b0;
            acc_hit   <= 1'b0;
            acc_multi <= 1'b0;
            acc_code  <= '0;
        end else if (frame_end) begin
            armed     <= 1'b1;
            acc_hit   <= 1'b0;
            acc_multi <= 1'b0;
            acc_code  <= '0;
        end else if (hit) begin
            if (!acc_hit) begin
                acc_hit  <= 1'b1;
                acc_code <= hit_code;
                if (!col_onehot) acc_multi <= 1'b1;
            end else if (hit_code != acc_code || !col_onehot) begin
                acc_multi <= 1'b1;
            end
        end
    end

    logic res_none, res_key;
    assign res_none = !acc_hit;
    assign res_key  = acc_hit && !acc_multi;

    estado_t    state, state_n;
    logic [3:0] cnt, cnt_n, cnt_inc, cand, cand_n, tecla_r, tecla_n;
    logic       valida_r, valida_n;

    assign cnt_inc = (cnt == 4'hF) ? cnt : cnt + 4'd1;

`ifdef TECLADO_REPEAT_EN
    localparam logic [5:0] REP_L = 6'(REP_FRAMES);
    logic [5:0] rep_cnt, rep_n, rep_inc;
    assign rep_inc = (rep_cnt == 6'h3F) ? rep_cnt : rep_cnt + 6'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rep_cnt <= '0;
        else        rep_cnt <= rep_n;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            cand     <= '0;
            tecla_r  <= '0;
            valida_r <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            cand     <= cand_n;
            tecla_r  <= tecla_n;
            valida_r <= valida_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        cand_n   = cand;
        tecla_n  = tecla_r;
        valida_n = 1'b0;
`ifdef TECLADO_REPEAT_EN
        rep_n    = (state == ST_HELD) ? rep_cnt : 6'd0;
`endif
        if (frame_end && armed) begin
            case (state)
                ST_IDLE: begin
                    if (res_key) begin
                        if (DEB_L == 4'd1) begin
                            state_n  = ST_HELD;
                            tecla_n  = acc_code;
                            valida_n = 1'b1;
                            cnt_n    = '0;
                        end else begin
                            state_n = ST_CONFIRM;
                            cand_n  = acc_code;
                            cnt_n   = 4'd1;
                        end
                    end
                end
                ST_CONFIRM: begin
                    if (res_key && acc_code == cand) begin
                        if (cnt_inc >= DEB_L) begin
                            state_n  = ST_HELD;
                            tecla_n  = cand;
                            valida_n = 1'b1;
                            cnt_n    = '0;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end else if (res_key) begin
                        cand_n = acc_code;
                        cnt_n  = 4'd1;
                    end else begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                    end
                end
                ST_HELD: begin
                    // A different key while held is ignored: a release must come first.
                    if (res_none) begin
                        state_n = (DEB_L == 4'd1) ? ST_IDLE : ST_RELEASE;
                        cnt_n   = (DEB_L == 4'd1) ? 4'd0 : 4'd1;
`ifdef TECLADO_REPEAT_EN
                        rep_n   = '0;
                    end else if (res_key && acc_code == tecla_r) begin
                        if (rep_inc >= REP_L) begin
                            valida_n = 1'b1;
                            rep_n    = '0;
                        end else begin
                            rep_n = rep_inc;
                        end
                    end else begin
                        rep_n = '0;
`endif
                    end
                end
                ST_RELEASE: begin
                    if (res_none) begin
                        if (cnt_inc >= DEB_L) begin
                            state_n = ST_IDLE;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end else begin
                        state_n = ST_HELD;
                        cnt_n   = '0;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    assign bus.tecla      = tecla_r;
    assign bus.valida     = valida_r;
    assign bus.presionada = (state == ST_HELD) || (state == ST_RELEASE);
endmodule

// File: tb/tb_decodificador_teclado.sv
// tb/tb_decodificador_teclado.sv - scoreboard bench for decodificador_teclado
module tb_decodificador_teclado;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decodificador_teclado_if bus();

    decodificador_teclado #(.DEB_FRAMES(3), .REP_FRAMES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int sb_q[$];
    logic valida_prev = 1'b0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One scanner phase of 4 clocks; the keypad closes the column of every
    // pressed key that sits on the driven row.
    task automatic phase(input logic [3:0] ent, input logic [15:0] mask);
        logic [3:0] sal;
        sal = 4'b0000;
        for (int r = 0; r < 4; r++)
            if (ent == (4'b1000 >> r))
                for (int c = 0; c < 4; c++)
                    if (mask[r*4 + c]) sal[3 - c] = 1'b1;
        bus.ent_teclado = ent;
        bus.sal_teclado = sal;
        repeat (4) @(negedge clk);
    endtask

    task automatic frames(input logic [15:0] mask, input int n);
        for (int i = 0; i < n; i++) begin
            phase(4'b1000, mask);
            phase(4'b0100, mask);
            phase(4'b0010, mask);
            phase(4'b0001, mask);
            phase(4'b1111, mask);
        end
    endtask

    function automatic logic [15:0] key(input int k);
        return 16'h0001 << k;
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.valida) begin
            check("valida_width", valida_prev, 0);
            check("presionada_on_strobe", bus.presionada, 1);
            check("strobe_expected", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) check("tecla_on_strobe", bus.tecla, sb_q.pop_front());
        end
        valida_prev = bus.valida;
    end

    initial begin
        bus.ent_teclado = 4'b0000;
        bus.sal_teclado = 4'b0000;
        repeat (3) @(negedge clk);
        check("rst_tecla", bus.tecla, 0);
        check("rst_valida", bus.valida, 0);
        check("rst_presionada", bus.presionada, 0);
        rst_n = 1'b1;
        @(negedge clk);
        phase(4'b1111, 16'h0);

        // Bounce: two good frames then a gap, twice.
        for (int i = 0; i < 2; i++) begin
            frames(key(6), 2);
            frames(16'h0, 1);
        end
        check("bounce_tecla", bus.tecla, 0);
        check("bounce_presionada", bus.presionada, 0);

        // Clean press of key 6.
        frames(key(6), 2);
        check("pre_accept_presionada", bus.presionada, 0);
        sb_q.push_back(6);
        frames(key(6), 1);
        check("accept_sb_drained", sb_q.size(), 0);
        check("accept_tecla", bus.tecla, 6);
        check("accept_presionada", bus.presionada, 1);
        frames(key(6), 2);
`ifdef TECLADO_REPEAT_EN
        frames(16'h0, 1);
`endif

        // Short release gap, then a real release.
        frames(16'h0, 2);
        check("gap_presionada", bus.presionada, 1);
        frames(key(6), 1);
        check("regrab_presionada", bus.presionada, 1);
        frames(16'h0, 2);
        check("release2_presionada", bus.presionada, 1);
        frames(16'h0, 1);
        check("release3_presionada", bus.presionada, 0);

        // Two keys in one frame, then key 15 alone.
        frames(key(0) | key(12), 5);
        check("multi_presionada", bus.presionada, 0);
        check("multi_tecla", bus.tecla, 6);
        frames(key(15), 2);
        sb_q.push_back(15);
        frames(key(15), 1);
        check("key15_sb_drained", sb_q.size(), 0);
        check("key15_tecla", bus.tecla, 15);
        frames(16'h0, 3);
        check("key15_released", bus.presionada, 0);

        // Long hold of key 5 (auto-repeat every 4 frames when enabled).
        frames(key(5), 2);
        sb_q.push_back(5);
        frames(key(5), 1);
        for (int i = 1; i <= 8; i++) begin
`ifdef TECLADO_REPEAT_EN
            if (i % 4 == 0) sb_q.push_back(5);
`endif
            frames(key(5), 1);
        end
        check("hold_sb_drained", sb_q.size(), 0);
        check("hold_tecla", bus.tecla, 5);
        frames(16'h0, 3);
        check("hold_released", bus.presionada, 0);

        // Reset in the middle of confirming key 9.
        frames(key(9), 2);
        bus.ent_teclado = 4'b0000;
        bus.sal_teclado = 4'b0000;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_tecla", bus.tecla, 0);
        check("midrst_valida", bus.valida, 0);
        check("midrst_presionada", bus.presionada, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        frames(key(9), 3);
        check("postrst_no_strobe_tecla", bus.tecla, 0);
        check("postrst_presionada", bus.presionada, 0);
        sb_q.push_back(9);
        frames(key(9), 1);
        check("postrst_sb_drained", sb_q.size(), 0);
        check("postrst_tecla", bus.tecla, 9);
        check("postrst_presionada_on", bus.presionada, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
